// File: rtl/serial_eq_compare_ctrl_if.sv
// Request/response bundle between a requester and the serial equality sequencer.
// The requester drives start and the operands; the sequencer returns status and result.
interface serial_eq_compare_ctrl_if #(
    parameter int W     = 5,
    parameter int IDX_W = 3
);
    logic             start;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             busy;
    logic             done;
    logic             eq;
    logic             mism_valid;
    logic [IDX_W-1:0] mism_idx;

    modport master (
        output start, x, y,
        input  busy, done, eq, mism_valid, mism_idx
    );

    modport slave (
        input  start, x, y,
        output busy, done, eq, mism_valid, mism_idx
    );
endinterface

// File: rtl/serial_eq_compare_ctrl.sv
// Word equality checker that reuses one XNOR cell across all bit positions,
// scanning LSB-first and reporting the lowest mismatching bit index.
module serial_eq_compare_ctrl #(
    parameter int W          = 5,
    parameter int IDX_W      = 3,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_eq_compare_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     xs_q;
    logic [W-1:0]     ys_q;
    logic [IDX_W-1:0] idx_q;
    logic             acc_q;
    logic             eq_q;
    logic             mism_valid_q;
    logic [IDX_W-1:0] mism_idx_q;

    logic bit_eq;
    logic last_bit;
    logic finish;

    // The single shared equality cell: always looks at bit 0 of the shifters.
    assign bit_eq   = ~(xs_q[0] ^ ys_q[0]);
    assign last_bit = (idx_q == IDX_W'(W - 1));
    assign finish   = last_bit | (EARLY_EXIT & ~bit_eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CMP;
            CMP:     if (finish) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // eq is loaded on the final compare so it is already valid in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q         <= '0;
            ys_q         <= '0;
            idx_q        <= '0;
            acc_q        <= 1'b0;
            eq_q         <= 1'b0;
            mism_valid_q <= 1'b0;
            mism_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        xs_q         <= bus.x;
                        ys_q         <= bus.y;
                        idx_q        <= '0;
                        acc_q        <= 1'b1;
                        eq_q         <= 1'b0;
                        mism_valid_q <= 1'b0;
                        mism_idx_q   <= '0;
                    end
                end
                CMP: begin
                    acc_q <= acc_q & bit_eq;
                    if (!bit_eq && !mism_valid_q) begin
                        mism_valid_q <= 1'b1;
                        mism_idx_q   <= idx_q;
                    end
                    if (finish) begin
                        eq_q <= acc_q & bit_eq;
                    end else begin
                        xs_q  <= xs_q >> 1;
                        ys_q  <= ys_q >> 1;
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q == CMP);
    assign bus.done       = (state_q == DONE);
    assign bus.eq         = eq_q;
    assign bus.mism_valid = mism_valid_q;
    assign bus.mism_idx   = mism_idx_q;
endmodule

// File: tb/tb_serial_eq_compare_ctrl.sv
// Bench for the serial equality sequencer: one full-scan and one early-exit
// instance share stimulus and are checked against a transaction-level model.
module tb_serial_eq_compare_ctrl;
    localparam int W     = 5;
    localparam int IDX_W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    bit           chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_eq_compare_ctrl_if #(.W(W), .IDX_W(IDX_W)) ifa ();
    serial_eq_compare_ctrl_if #(.W(W), .IDX_W(IDX_W)) ifb ();

    assign ifa.start = start;
    assign ifa.x     = x;
    assign ifa.y     = y;
    assign ifb.start = start;
    assign ifb.x     = x;
    assign ifb.y     = y;

    serial_eq_compare_ctrl #(.W(W), .IDX_W(IDX_W), .EARLY_EXIT(1'b0)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    serial_eq_compare_ctrl #(.W(W), .IDX_W(IDX_W), .EARLY_EXIT(1'b1)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    logic             d_busy [2];
    logic             d_done [2];
    logic             d_eq   [2];
    logic             d_mv   [2];
    logic [IDX_W-1:0] d_mi   [2];

    assign d_busy[0] = ifa.busy;
    assign d_done[0] = ifa.done;
    assign d_eq[0]   = ifa.eq;
    assign d_mv[0]   = ifa.mism_valid;
    assign d_mi[0]   = ifa.mism_idx;
    assign d_busy[1] = ifb.busy;
    assign d_done[1] = ifb.done;
    assign d_eq[1]   = ifb.eq;
    assign d_mv[1]   = ifb.mism_valid;
    assign d_mi[1]   = ifb.mism_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            if (d[i]) return i;
        end
        return 0;
    endfunction

    // Cycles from accept to done, derived from the operand difference alone.
    function automatic int latency_of(input logic [W-1:0] a, input logic [W-1:0] b, input bit early);
        if (early && (a != b)) return lowest_set(a ^ b) + 2;
        return W + 1;
    endfunction

    bit m_act [2];
    int m_cnt [2];
    int m_lat [2];
    bit p_eq  [2];
    bit p_mv  [2];
    int p_mi  [2];
    bit e_eq  [2];
    bit e_mv  [2];
    int e_mi  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_cnt[i] <= 0;
                m_lat[i] <= 0;
                p_eq[i]  <= 1'b0;
                p_mv[i]  <= 1'b0;
                p_mi[i]  <= 0;
                e_eq[i]  <= 1'b0;
                e_mv[i]  <= 1'b0;
                e_mi[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (start === 1'b1) begin
                        m_act[i] <= 1'b1;
                        m_cnt[i] <= 1;
                        m_lat[i] <= latency_of(x, y, i == 1);
                        p_eq[i]  <= (x == y);
                        p_mv[i]  <= (x != y);
                        p_mi[i]  <= lowest_set(x ^ y);
                        e_eq[i]  <= 1'b0;
                        e_mv[i]  <= 1'b0;
                        e_mi[i]  <= 0;
                    end
                end else if (m_cnt[i] == m_lat[i]) begin
                    m_act[i] <= 1'b0;
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                    if (m_cnt[i] + 1 == m_lat[i]) begin
                        e_eq[i] <= p_eq[i];
                        e_mv[i] <= p_mv[i];
                        e_mi[i] <= p_mi[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit xb, xd;
                xb = m_act[i] && (m_cnt[i] < m_lat[i]);
                xd = m_act[i] && (m_cnt[i] == m_lat[i]);
                chk($sformatf("busy%0d", i), 32'(d_busy[i]), 32'(xb));
                chk($sformatf("done%0d", i), 32'(d_done[i]), 32'(xd));
                chk($sformatf("eq%0d", i), 32'(d_eq[i]), xb ? 32'd0 : 32'(e_eq[i]));
                if (!xb) begin
                    chk($sformatf("mism_valid%0d", i), 32'(d_mv[i]), 32'(e_mv[i]));
                    chk($sformatf("mism_idx%0d", i), 32'(d_mi[i]), 32'(e_mi[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start must already be driven; poke replays a start with new x during busy.
    task automatic wait_both(input string tag, input int la, input int lb,
                             input bit leq, input bit lmv, input int lmi, input bit poke);
        int na, nb;
        na = -1;
        nb = -1;
        for (int n = 1; n <= 25 && (na < 0 || nb < 0); n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (poke && n == 2) begin
                start = 1'b1;
                x     = 5'b11111;
            end
            if (poke && n == 3) start = 1'b0;
            if (ifa.done === 1'b1 && na < 0) begin
                na = n;
                chk({tag, "_eq_a"}, 32'(ifa.eq), 32'(leq));
                chk({tag, "_mv_a"}, 32'(ifa.mism_valid), 32'(lmv));
                chk({tag, "_mi_a"}, 32'(ifa.mism_idx), 32'(lmi));
            end
            if (ifb.done === 1'b1 && nb < 0) begin
                nb = n;
                chk({tag, "_eq_b"}, 32'(ifb.eq), 32'(leq));
                chk({tag, "_mv_b"}, 32'(ifb.mism_valid), 32'(lmv));
                chk({tag, "_mi_b"}, 32'(ifb.mism_idx), 32'(lmi));
            end
        end
        chk({tag, "_lat_a"}, 32'(na), 32'(la));
        chk({tag, "_lat_b"}, 32'(nb), 32'(lb));
        tick();
    endtask

    task automatic txn(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input int la, input int lb, input bit leq, input bit lmv, input int lmi);
        x     = xv;
        y     = yv;
        start = 1'b1;
        wait_both(tag, la, lb, leq, lmv, lmi, 1'b0);
    endtask

    initial begin
        int d1a, d2a, d1b, d2b;
        chk_en = 1'b1;
        repeat (2) tick();
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_eq", 32'(ifa.eq), 32'd0);
        chk("rst_mv", 32'(ifa.mism_valid), 32'd0);
        chk("rst_mi", 32'(ifa.mism_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        txn("zeros", 5'b00000, 5'b00000, 6, 6, 1'b1, 1'b0, 0);
        txn("ones",  5'b11111, 5'b11111, 6, 6, 1'b1, 1'b0, 0);
        txn("bit3",  5'b10111, 5'b11111, 6, 5, 1'b0, 1'b1, 3);
        txn("bit0_4", 5'b01110, 5'b11111, 6, 2, 1'b0, 1'b1, 0);
        txn("bit4",  5'b10000, 5'b00000, 6, 6, 1'b0, 1'b1, 4);
        txn("mixed", 5'b01010, 5'b01110, 6, 4, 1'b0, 1'b1, 2);

        // A start and an operand change while busy must both be ignored.
        x     = 5'b00000;
        y     = 5'b00000;
        start = 1'b1;
        wait_both("busy_start", 6, 6, 1'b1, 1'b0, 0, 1'b1);
        x = 5'b00000;

        // Reset in the middle of a compare abandons it.
        x     = 5'b11111;
        y     = 5'b11111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_a", 32'(ifa.busy), 32'd0);
        chk("mid_rst_busy_b", 32'(ifb.busy), 32'd0);
        chk("mid_rst_done_a", 32'(ifa.done), 32'd0);
        chk("mid_rst_eq_a", 32'(ifa.eq), 32'd0);
        chk("mid_rst_mv_a", 32'(ifa.mism_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        x     = 5'b10111;
        y     = 5'b11111;
        start = 1'b1;
        wait_both("after_rst", 6, 5, 1'b0, 1'b1, 3, 1'b0);

        // start held high: back-to-back compares with a one-cycle gap.
        x     = 5'b10101;
        y     = 5'b10101;
        start = 1'b1;
        d1a = -1; d2a = -1; d1b = -1; d2b = -1;
        for (int n = 1; n <= 30 && d2a < 0; n++) begin
            tick();
            if (ifa.done === 1'b1) begin
                if (d1a < 0) d1a = n; else d2a = n;
            end
            if (ifb.done === 1'b1) begin
                if (d1b < 0) d1b = n; else d2b = n;
            end
        end
        start = 1'b0;
        chk("held_done1_a", 32'(d1a), 32'd6);
        chk("held_done2_a", 32'(d2a), 32'd13);
        chk("held_done1_b", 32'(d1b), 32'd6);
        chk("held_done2_b", 32'(d2b), 32'd13);
        chk("held_eq_a", 32'(ifa.eq), 32'd1);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
